nvr_bootread: RTL
=================

NVR_BOOTREAD -- requirements
Module: nvr_bootread

Interface
REQ-001 SHALL have parameter BRC, default 128, meaning the row-index space; BRCW = $clog2(BRC).
REQ-002 SHALL have parameter BRDW, default 256, meaning the row data width.
REQ-003 SHALL have parameters BRNUM_CMS=1, BRNUM_IPM=3, BRNUM_CFG=12, giving group row counts; NROW = the sum of the three (16).
REQ-004 SHALL have parameter RDBASE, default 0, meaning the NVR address of row 0; RETRY, default 2, meaning retries per row on error.
REQ-005 SHALL be clocked by a single clock, and its reset SHALL be synchronous and active-high.
REQ-006 SHALL have port `clk`, input, 1 bit: the clock.
REQ-007 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port `start`, input, 1 bit: pulse that begins the boot read; it is honoured only in IDLE.
REQ-009 SHALL have port `rd_req`, output, 1 bit: NVR read request, held until acknowledged.
REQ-010 SHALL have port `rd_addr`, output, BRCW bits: NVR row address, equal to RDBASE + idx.
REQ-011 SHALL have ports `rd_ack` (input, 1 bit), `rd_data` (input, BRDW bits) and `rd_err` (input, 1 bit); all three are valid in the rd_ack cycle.
REQ-012 SHALL have port `brvld`, output, 1 bit: one-cycle row-valid strobe.
REQ-013 SHALL have port `bridx`, output, BRCW bits: row index of the current row.
REQ-014 SHALL have port `brdat`, output, BRDW bits: row data.
REQ-015 SHALL have port `brready`, input, 4 bits: per-group consumer ready ([0] CMS, [1] IPM, [2] CFG, [3] final).
REQ-016 SHALL have port `brdone`, output, 1 bit: sticky boot-read-complete flag.
REQ-017 SHALL have port `brerr`, output, 1 bit: sticky flag meaning at least one row failed after all retries.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, EMIT, GAP, GWAIT, DONE.
REQ-019 SHALL move IDLE->REQ on start=1, with idx=0 and retry count=0.
REQ-020 SHALL hold rd_req=1 in REQ and keep rd_addr stable until rd_ack; rd_req SHALL drop in the cycle after the ack.
REQ-021 SHALL, on rd_ack with rd_err=0, capture rd_data into brdat and go to EMIT.
REQ-022 SHALL, on rd_ack with rd_err=1 and retry count < RETRY, increment the retry count and stay in REQ with the same address.
REQ-023 SHALL, on rd_ack with rd_err=1 and retry count = RETRY, set brdat to all-zeros, set brerr, and go to EMIT.
REQ-024 SHALL drive brvld=1 for exactly one cycle in EMIT, with bridx=idx.
REQ-025 SHALL hold bridx and brdat stable from the EMIT cycle until the next EMIT cycle; the consumer samples brdat up to 2 cycles after brvld.
REQ-026 SHALL, in GAP, wait 2 cycles so that the minimum brvld-to-brvld spacing is 4 cycles; it then clears the retry count.
REQ-027 SHALL, leaving GAP, go to GWAIT if idx is the last row of a group (idx = 0, 3 or 15 at default parameters); otherwise it increments idx and goes to REQ.
REQ-028 SHALL, in GWAIT, wait for brready[g] of the current group g; on brready[g]=1 it increments idx and goes to REQ, or goes to DONE if idx = NROW-1.
REQ-029 SHALL reach DONE only after the CFG group has ended and brready[2] and then brready[3] have been seen (brready[3] is sampled after brready[2]).
REQ-030 SHALL assert brdone in DONE and hold it until reset; start SHALL be ignored in DONE.
REQ-031 SHALL ignore a brready bit that is already 1 before its group completes; only the level seen in GWAIT counts.
REQ-032 SHALL count idx over 0..NROW-1 only and never wrap it; rd_addr SHALL be computed modulo 2^BRCW.
REQ-033 SHALL ignore rd_ack outside REQ.

Reset
REQ-034 SHALL, on reset=1 at a clock edge, enter IDLE and clear rd_req, rd_addr, brvld, bridx, brdat, brdone, brerr, idx and the retry count to 0.
REQ-035 SHALL let reset override every state mid-operation; an outstanding read is abandoned and a late rd_ack after reset is ignored.
REQ-036 SHALL keep all outputs at their reset values until the first start after reset.

Verification
REQ-037 SHALL pass clean boot: start, rd_ack with 1-cycle latency and no errors, brready all 1 -> 16 brvld pulses with bridx 0..15 and spacing of at least 4 cycles; brdat equals the model row data; then brdone=1 and brerr=0.
REQ-038 SHALL pass group stall: hold brready[1]=0 for 50 cycles after row 3 -> no rd_req while stalled, and rd_addr=4 in the cycle after brready[1] rises.
REQ-039 SHALL pass retry success: rd_err=1 twice on row 5, then clean -> 3 requests to address 5; brdat equals the data of the third read; brerr=0.
REQ-040 SHALL pass retry exhaustion: rd_err=1 three times on row 2 -> brvld with bridx=2 and brdat=0; brerr=1 and sticky; the sequence continues to brdone.
REQ-041 SHALL pass reset mid-read: reset asserted while in REQ for row 7, then a late rd_ack -> all outputs 0, no brvld; a new start restarts from bridx=0.
REQ-042 SHALL pass start-in-DONE: a start pulse after brdone -> no rd_req, and brdone stays 1.

Source files
------------

// File: rtl/nvr_bootread.sv
// Boot-time NVR row reader: fetches NROW rows with per-row retry, strobes each row out,
// and paces group boundaries on consumer ready before flagging completion.
//   state | meaning
//   IDLE  | waiting for start
//   REQ   | read request outstanding for row idx
//   EMIT  | one-cycle row-valid strobe
//   GAP   | two-cycle spacing after a strobe
//   GWAIT | group boundary, waiting for brready of the group
//   DONE  | all rows delivered, sticky until reset
module nvr_bootread #(
    parameter  int BRC       = 128,
    parameter  int BRDW      = 256,
    parameter  int BRNUM_CMS = 1,
    parameter  int BRNUM_IPM = 3,
    parameter  int BRNUM_CFG = 12,
    parameter  int RDBASE    = 0,
    parameter  int RETRY     = 2,
    localparam int BRCW      = $clog2(BRC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            rd_req,
    output logic [BRCW-1:0] rd_addr,
    input  logic            rd_ack,
    input  logic [BRDW-1:0] rd_data,
    input  logic            rd_err,
    output logic            brvld,
    output logic [BRCW-1:0] bridx,
    output logic [BRDW-1:0] brdat,
    input  logic [3:0]      brready,
    output logic            brdone,
    output logic            brerr
);
    localparam int NROW = BRNUM_CMS + BRNUM_IPM + BRNUM_CFG;
    localparam int RW   = (RETRY > 0) ? $clog2(RETRY + 1) : 1;

    localparam logic [BRCW-1:0] LAST0     = BRCW'(BRNUM_CMS - 1);
    localparam logic [BRCW-1:0] LAST1     = BRCW'(BRNUM_CMS + BRNUM_IPM - 1);
    localparam logic [BRCW-1:0] LAST2     = BRCW'(NROW - 1);
    localparam logic [BRCW-1:0] BASE      = BRCW'(RDBASE);
    localparam logic [RW-1:0]   RETRY_MAX = RW'(RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_EMIT, S_GAP, S_GWAIT, S_DONE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [BRCW-1:0] r_idx, w_idx_nxt;
    logic [BRCW-1:0] r_rd_addr, w_rd_addr_nxt;
    logic [BRCW-1:0] r_bridx, w_bridx_nxt;
    logic [BRDW-1:0] r_brdat, w_brdat_nxt;
    logic [RW-1:0]   r_retry, w_retry_nxt;
    logic            r_gap, w_gap_nxt;
    logic [1:0]      r_grp, w_grp_nxt;
    logic            r_brerr, w_brerr_nxt;
    logic            w_grp_last;
    logic [1:0]      w_grp_of_idx;

    always_comb begin
        w_grp_last    = (r_idx == LAST0) || (r_idx == LAST1) || (r_idx == LAST2);
        w_grp_of_idx  = (r_idx <= LAST0) ? 2'd0 : ((r_idx <= LAST1) ? 2'd1 : 2'd2);
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_rd_addr_nxt = r_rd_addr;
        w_bridx_nxt   = r_bridx;
        w_brdat_nxt   = r_brdat;
        w_retry_nxt   = r_retry;
        w_gap_nxt     = r_gap;
        w_grp_nxt     = r_grp;
        w_brerr_nxt   = r_brerr;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt   = S_REQ;
                    w_idx_nxt     = '0;
                    w_retry_nxt   = '0;
                    w_rd_addr_nxt = BASE;
                end
            end
            S_REQ: begin
                if (rd_ack) begin
                    if (!rd_err) begin
                        w_brdat_nxt = rd_data;
                        w_bridx_nxt = r_idx;
                        w_state_nxt = S_EMIT;
                    end else if (r_retry < RETRY_MAX) begin
                        w_retry_nxt = r_retry + RW'(1);
                    end else begin
                        // Row is unreadable: deliver zeros so the consumer still sees every index.
                        w_brdat_nxt = '0;
                        w_brerr_nxt = 1'b1;
                        w_bridx_nxt = r_idx;
                        w_state_nxt = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                w_gap_nxt   = 1'b1;
                w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (r_gap) begin
                    w_gap_nxt = 1'b0;
                end else begin
                    w_retry_nxt = '0;
                    if (w_grp_last) begin
                        w_grp_nxt   = w_grp_of_idx;
                        w_state_nxt = S_GWAIT;
                    end else begin
                        w_idx_nxt     = r_idx + BRCW'(1);
                        w_rd_addr_nxt = BASE + r_idx + BRCW'(1);
                        w_state_nxt   = S_REQ;
                    end
                end
            end
            S_GWAIT: begin
                // After the CFG group, the final-ready bit is sampled in a later cycle.
                if (brready[r_grp]) begin
                    if (r_grp == 2'd2) begin
                        w_grp_nxt = 2'd3;
                    end else if (r_grp == 2'd3) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt     = r_idx + BRCW'(1);
                        w_rd_addr_nxt = BASE + r_idx + BRCW'(1);
                        w_state_nxt   = S_REQ;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_rd_addr <= '0;
            r_bridx   <= '0;
            r_brdat   <= '0;
            r_retry   <= '0;
            r_gap     <= 1'b0;
            r_grp     <= 2'd0;
            r_brerr   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_bridx   <= w_bridx_nxt;
            r_brdat   <= w_brdat_nxt;
            r_retry   <= w_retry_nxt;
            r_gap     <= w_gap_nxt;
            r_grp     <= w_grp_nxt;
            r_brerr   <= w_brerr_nxt;
        end
    end

    assign rd_req  = (r_state == S_REQ);
    assign rd_addr = r_rd_addr;
    assign brvld   = (r_state == S_EMIT);
    assign bridx   = r_bridx;
    assign brdat   = r_brdat;
    assign brdone  = (r_state == S_DONE);
    assign brerr   = r_brerr;
endmodule
